// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, ALU opcodes and the OF/EX latch bundle.
package pipe_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 4;
  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_DIV = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_MOD = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_CMP = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_NOT = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_MOV = 5'b01001;
  localparam logic [ALU_OP_W-1:0] ALU_LSL = 5'b01010;
  localparam logic [ALU_OP_W-1:0] ALU_LSR = 5'b01011;
  localparam logic [ALU_OP_W-1:0] ALU_ASR = 5'b01100;
  localparam logic [ALU_OP_W-1:0] ALU_NOP = 5'b01101;
  localparam logic [ALU_OP_W-1:0] ALU_LD  = 5'b01110;
  localparam logic [ALU_OP_W-1:0] ALU_ST  = 5'b01111;

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   pc;
    logic [ALU_OP_W-1:0] alusignals;
    logic                is_imm;
    logic [DATA_W-1:0]   imm;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic                use_rs1;
    logic                use_rs2;
    logic [DATA_W-1:0]   op1;
    logic [DATA_W-1:0]   op2;
    logic [REG_AW-1:0]   rd;
    logic                wb_en;
    logic                is_load;
    logic                is_store;
  } of_ex_t;

  // Empty latch: everything zero except the opcode, which idles as NOP.
  function automatic of_ex_t of_ex_empty();
    of_ex_t e;
    e            = '0;
    e.alusignals = ALU_NOP;
    return e;
  endfunction

endpackage

// File: rtl/of_ex_stage_if.sv
// Bundle of OF-side inputs, MA/RW status and EX-side outputs of the OF/EX stage.
interface of_ex_stage_if;
  import pipe_pkg::*;

  logic                of_valid;
  logic [DATA_W-1:0]   of_pc;
  logic [ALU_OP_W-1:0] of_alusignals;
  logic                of_is_imm;
  logic [DATA_W-1:0]   of_imm;
  logic [REG_AW-1:0]   of_rs1;
  logic [REG_AW-1:0]   of_rs2;
  logic                of_use_rs1;
  logic                of_use_rs2;
  logic [DATA_W-1:0]   of_op1;
  logic [DATA_W-1:0]   of_op2;
  logic [REG_AW-1:0]   of_rd;
  logic                of_wb_en;
  logic                of_is_load;
  logic                of_is_store;
  logic                ma_valid;
  logic                ma_wb_en;
  logic                ma_is_load;
  logic [REG_AW-1:0]   ma_rd;
  logic [DATA_W-1:0]   ma_result;
  logic                rw_valid;
  logic                rw_wb_en;
  logic [REG_AW-1:0]   rw_rd;
  logic [DATA_W-1:0]   rw_result;
  logic                flush;
  logic                stall_of;
  logic                ex_valid;
  logic [DATA_W-1:0]   ex_pc;
  logic [DATA_W-1:0]   ex_a;
  logic [DATA_W-1:0]   ex_b;
  logic [ALU_OP_W-1:0] ex_alusignals;
  logic [DATA_W-1:0]   ex_store_data;
  logic [REG_AW-1:0]   ex_rd;
  logic                ex_wb_en;
  logic                ex_is_load;
  logic                ex_is_store;

  modport master (
    output of_valid, of_pc, of_alusignals, of_is_imm, of_imm, of_rs1, of_rs2,
           of_use_rs1, of_use_rs2, of_op1, of_op2, of_rd, of_wb_en, of_is_load,
           of_is_store, ma_valid, ma_wb_en, ma_is_load, ma_rd, ma_result,
           rw_valid, rw_wb_en, rw_rd, rw_result, flush,
    input  stall_of, ex_valid, ex_pc, ex_a, ex_b, ex_alusignals, ex_store_data,
           ex_rd, ex_wb_en, ex_is_load, ex_is_store
  );

  modport slave (
    input  of_valid, of_pc, of_alusignals, of_is_imm, of_imm, of_rs1, of_rs2,
           of_use_rs1, of_use_rs2, of_op1, of_op2, of_rd, of_wb_en, of_is_load,
           of_is_store, ma_valid, ma_wb_en, ma_is_load, ma_rd, ma_result,
           rw_valid, rw_wb_en, rw_rd, rw_result, flush,
    output stall_of, ex_valid, ex_pc, ex_a, ex_b, ex_alusignals, ex_store_data,
           ex_rd, ex_wb_en, ex_is_load, ex_is_store
  );

endinterface

// File: rtl/of_ex_stage_fwd_mux.sv
// Operand forwarding selector: MA result beats RW result beats the latched register value.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              ma_valid,
  input  logic              ma_wb_en,
  input  logic              ma_is_load,
  input  logic [REG_AW-1:0] ma_rd,
  input  logic [DATA_W-1:0] ma_result,
  input  logic              rw_valid,
  input  logic              rw_wb_en,
  input  logic [REG_AW-1:0] rw_rd,
  input  logic [DATA_W-1:0] rw_result,
  output logic [DATA_W-1:0] fwd_val
);

  logic ma_hit;
  logic rw_hit;

  // A load in MA has no data yet, so only RW can supply its value.
  always_comb begin
    ma_hit = use_rs & ma_valid & ma_wb_en & ~ma_is_load & (ma_rd == rs);
    rw_hit = use_rs & rw_valid & rw_wb_en & (rw_rd == rs);
    if (ma_hit) begin
      fwd_val = ma_result;
    end else if (rw_hit) begin
      fwd_val = rw_result;
    end else begin
      fwd_val = reg_val;
    end
  end

endmodule

// File: rtl/of_ex_stage.sv
// OF/EX pipeline latch with load-use interlock and MA/RW operand forwarding.
module of_ex_stage
  import pipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  of_ex_stage_if.slave  bus
);

  of_ex_t of_s;
  of_ex_t ex_d;
  of_ex_t ex_q;
  logic   stall_s;
  logic [DATA_W-1:0] fwd1_s;
  logic [DATA_W-1:0] fwd2_s;

  always_comb begin
    of_s.valid      = bus.of_valid;
    of_s.pc         = bus.of_pc;
    of_s.alusignals = bus.of_alusignals;
    of_s.is_imm     = bus.of_is_imm;
    of_s.imm        = bus.of_imm;
    of_s.rs1        = bus.of_rs1;
    of_s.rs2        = bus.of_rs2;
    of_s.use_rs1    = bus.of_use_rs1;
    of_s.use_rs2    = bus.of_use_rs2;
    of_s.op1        = bus.of_op1;
    of_s.op2        = bus.of_op2;
    of_s.rd         = bus.of_rd;
    of_s.wb_en      = bus.of_wb_en;
    of_s.is_load    = bus.of_is_load;
    of_s.is_store   = bus.of_is_store;
  end

  // A load in EX blocks a dependent OF instruction for the one cycle before its data reaches RW.
  always_comb begin
    stall_s = ex_q.valid & ex_q.is_load & ex_q.wb_en & bus.of_valid &
              ((bus.of_use_rs1 & (bus.of_rs1 == ex_q.rd)) |
               (bus.of_use_rs2 & (bus.of_rs2 == ex_q.rd))) &
              ~bus.flush;
  end

  always_comb begin
    ex_d = ex_q;
    if (bus.flush || stall_s) begin
      ex_d.valid      = 1'b0;
      ex_d.wb_en      = 1'b0;
      ex_d.is_load    = 1'b0;
      ex_d.is_store   = 1'b0;
      ex_d.alusignals = ALU_NOP;
    end else begin
      ex_d = of_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= of_ex_empty();
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux u_fwd1 (
    .rs        (ex_q.rs1),
    .use_rs    (ex_q.use_rs1),
    .reg_val   (ex_q.op1),
    .ma_valid  (bus.ma_valid),
    .ma_wb_en  (bus.ma_wb_en),
    .ma_is_load(bus.ma_is_load),
    .ma_rd     (bus.ma_rd),
    .ma_result (bus.ma_result),
    .rw_valid  (bus.rw_valid),
    .rw_wb_en  (bus.rw_wb_en),
    .rw_rd     (bus.rw_rd),
    .rw_result (bus.rw_result),
    .fwd_val   (fwd1_s)
  );

  // Operand 2 also carries the store value, so it forwards regardless of is_imm.
  fwd_mux u_fwd2 (
    .rs        (ex_q.rs2),
    .use_rs    (ex_q.use_rs2),
    .reg_val   (ex_q.op2),
    .ma_valid  (bus.ma_valid),
    .ma_wb_en  (bus.ma_wb_en),
    .ma_is_load(bus.ma_is_load),
    .ma_rd     (bus.ma_rd),
    .ma_result (bus.ma_result),
    .rw_valid  (bus.rw_valid),
    .rw_wb_en  (bus.rw_wb_en),
    .rw_rd     (bus.rw_rd),
    .rw_result (bus.rw_result),
    .fwd_val   (fwd2_s)
  );

  assign bus.stall_of      = stall_s;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_a          = fwd1_s;
  assign bus.ex_b          = ex_q.is_imm ? ex_q.imm : fwd2_s;
  assign bus.ex_alusignals = ex_q.alusignals;
  assign bus.ex_store_data = fwd2_s;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_wb_en      = ex_q.wb_en;
  assign bus.ex_is_load    = ex_q.is_load;
  assign bus.ex_is_store   = ex_q.is_store;

endmodule

// File: tb/tb_of_ex_stage.sv
// Directed bench for of_ex_stage: per-cycle comparison against an instruction-level model plus literal checks.
module tb_of_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  of_ex_stage_if bus();
  of_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  op;
    logic        is_imm;
    logic [31:0] imm;
    logic [3:0]  rs1, rs2;
    logic        u1, u2;
    logic [31:0] v1, v2;
    logic [3:0]  rd;
    logic        wb, ld, st;
  } instr_t;

  instr_t ex_m;   // what the EX stage should currently hold

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] operand(input logic [3:0] rs, input logic u, input logic [31:0] v);
    if (!u) return v;
    if (bus.ma_valid && bus.ma_wb_en && !bus.ma_is_load && bus.ma_rd == rs) return bus.ma_result;
    if (bus.rw_valid && bus.rw_wb_en && bus.rw_rd == rs) return bus.rw_result;
    return v;
  endfunction

  function automatic logic want_stall();
    logic dep;
    dep = (bus.of_use_rs1 && bus.of_rs1 == ex_m.rd) || (bus.of_use_rs2 && bus.of_rs2 == ex_m.rd);
    return ex_m.valid && ex_m.ld && ex_m.wb && bus.of_valid && dep && !bus.flush;
  endfunction

  // Instruction-level model of what moves into EX at each edge.
  always @(posedge clk) begin
    if (rst || bus.flush || want_stall()) begin
      ex_m.valid <= 1'b0;
      ex_m.wb    <= 1'b0;
      ex_m.ld    <= 1'b0;
      ex_m.st    <= 1'b0;
      ex_m.op    <= 5'b01101;
    end else begin
      ex_m <= '{bus.of_valid, bus.of_pc, bus.of_alusignals, bus.of_is_imm, bus.of_imm,
                bus.of_rs1, bus.of_rs2, bus.of_use_rs1, bus.of_use_rs2, bus.of_op1,
                bus.of_op2, bus.of_rd, bus.of_wb_en, bus.of_is_load, bus.of_is_store};
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("m_stall", {31'd0, bus.stall_of}, {31'd0, want_stall()});
    chk("m_valid", {31'd0, bus.ex_valid}, {31'd0, ex_m.valid});
    chk("m_wb_en", {31'd0, bus.ex_wb_en}, {31'd0, ex_m.wb});
    chk("m_is_load", {31'd0, bus.ex_is_load}, {31'd0, ex_m.ld});
    chk("m_is_store", {31'd0, bus.ex_is_store}, {31'd0, ex_m.st});
    if (ex_m.valid) begin
      chk("m_pc", bus.ex_pc, ex_m.pc);
      chk("m_alu", {27'd0, bus.ex_alusignals}, {27'd0, ex_m.op});
      chk("m_rd", {28'd0, bus.ex_rd}, {28'd0, ex_m.rd});
      chk("m_a", bus.ex_a, operand(ex_m.rs1, ex_m.u1, ex_m.v1));
      chk("m_b", bus.ex_b, ex_m.is_imm ? ex_m.imm : operand(ex_m.rs2, ex_m.u2, ex_m.v2));
      chk("m_store", bus.ex_store_data, operand(ex_m.rs2, ex_m.u2, ex_m.v2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_of();
    bus.of_valid = 1'b0; bus.of_pc = 32'd0; bus.of_alusignals = 5'b01101;
    bus.of_is_imm = 1'b0; bus.of_imm = 32'd0; bus.of_rs1 = 4'd0; bus.of_rs2 = 4'd0;
    bus.of_use_rs1 = 1'b0; bus.of_use_rs2 = 1'b0; bus.of_op1 = 32'd0; bus.of_op2 = 32'd0;
    bus.of_rd = 4'd0; bus.of_wb_en = 1'b0; bus.of_is_load = 1'b0; bus.of_is_store = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] op,
                       input logic [3:0] rs1, input logic u1, input logic [31:0] v1,
                       input logic [3:0] rs2, input logic u2, input logic [31:0] v2,
                       input logic [3:0] rd, input logic wb, input logic ld, input logic st,
                       input logic is_imm, input logic [31:0] imm);
    bus.of_valid = 1'b1; bus.of_pc = pc; bus.of_alusignals = op;
    bus.of_rs1 = rs1; bus.of_use_rs1 = u1; bus.of_op1 = v1;
    bus.of_rs2 = rs2; bus.of_use_rs2 = u2; bus.of_op2 = v2;
    bus.of_rd = rd; bus.of_wb_en = wb; bus.of_is_load = ld; bus.of_is_store = st;
    bus.of_is_imm = is_imm; bus.of_imm = imm;
  endtask

  task automatic set_ma(input logic v, input logic wb, input logic ld, input logic [3:0] rd, input logic [31:0] res);
    bus.ma_valid = v; bus.ma_wb_en = wb; bus.ma_is_load = ld; bus.ma_rd = rd; bus.ma_result = res;
  endtask

  task automatic set_rw(input logic v, input logic wb, input logic [3:0] rd, input logic [31:0] res);
    bus.rw_valid = v; bus.rw_wb_en = wb; bus.rw_rd = rd; bus.rw_result = res;
  endtask

  initial begin
    clr_of();
    bus.flush = 1'b0;
    set_ma(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    set_rw(1'b0, 1'b0, 4'd0, 32'd0);

    // Reset held for two cycles with a valid instruction offered.
    rst = 1'b1;
    issue(32'h10, 5'b00000, 4'd1, 1'b1, 32'h1, 4'd2, 1'b1, 32'h2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    step();
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_alu", {27'd0, bus.ex_alusignals}, 32'h0000000d);
    chk("rst_stall", {31'd0, bus.stall_of}, 32'd0);
    chk("rst_ctl", {29'd0, bus.ex_wb_en, bus.ex_is_load, bus.ex_is_store}, 32'd0);
    rst = 1'b0;
    clr_of();
    step();

    // MA forward to operand 1; operand 2 unaffected.
    issue(32'h20, 5'b00001, 4'd3, 1'b1, 32'h11, 4'd4, 1'b1, 32'h7, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    clr_of();
    set_ma(1'b1, 1'b1, 1'b0, 4'd3, 32'h55);
    @(negedge clk);
    chk("maf_a", bus.ex_a, 32'h55);
    chk("maf_b", bus.ex_b, 32'h7);
    chk("maf_valid", {31'd0, bus.ex_valid}, 32'd1);

    // MA beats RW; with MA not writing, RW supplies the value.
    step();
    issue(32'h24, 5'b00000, 4'd5, 1'b1, 32'h99, 4'd0, 1'b0, 32'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    clr_of();
    set_ma(1'b1, 1'b1, 1'b0, 4'd5, 32'hA);
    set_rw(1'b1, 1'b1, 4'd5, 32'hB);
    @(negedge clk);
    chk("prio_ma", bus.ex_a, 32'hA);
    bus.ma_wb_en = 1'b0;
    #1;
    chk("prio_rw", bus.ex_a, 32'hB);

    // Load-use: one stall cycle, one bubble, then RW forwards the load data.
    step();
    set_ma(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    set_rw(1'b0, 1'b0, 4'd0, 32'd0);
    issue(32'h30, 5'b01110, 4'd1, 1'b1, 32'h40, 4'd0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4);
    step();
    issue(32'h34, 5'b00000, 4'd2, 1'b1, 32'h0, 4'd1, 1'b1, 32'h10, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("lu_stall", {31'd0, bus.stall_of}, 32'd1);
    step();
    set_ma(1'b1, 1'b1, 1'b1, 4'd2, 32'h777);
    @(negedge clk);
    chk("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
    chk("lu_stall_once", {31'd0, bus.stall_of}, 32'd0);
    step();
    clr_of();
    set_ma(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    set_rw(1'b1, 1'b1, 4'd2, 32'h1234);
    @(negedge clk);
    chk("lu_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("lu_a", bus.ex_a, 32'h1234);
    chk("lu_b", bus.ex_b, 32'h10);
    set_ma(1'b1, 1'b1, 1'b1, 4'd2, 32'h5);
    #1;
    chk("lu_no_ma_load", bus.ex_a, 32'h1234);

    // Flush overrides a load-use stall and empties EX.
    step();
    set_ma(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    set_rw(1'b0, 1'b0, 4'd0, 32'd0);
    issue(32'h40, 5'b01110, 4'd1, 1'b1, 32'h40, 4'd0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4);
    step();
    issue(32'h44, 5'b00000, 4'd2, 1'b1, 32'h0, 4'd1, 1'b1, 32'h10, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_stall", {31'd0, bus.stall_of}, 32'd0);
    step();
    bus.flush = 1'b0;
    clr_of();
    @(negedge clk);
    chk("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("fl_ctl", {29'd0, bus.ex_wb_en, bus.ex_is_load, bus.ex_is_store}, 32'd0);

    // Store with immediate offset: b is the immediate, store data forwards from MA.
    step();
    issue(32'h50, 5'b01111, 4'd1, 1'b1, 32'h100, 4'd6, 1'b1, 32'h3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8);
    step();
    clr_of();
    set_ma(1'b1, 1'b1, 1'b0, 4'd6, 32'hDEAD);
    @(negedge clk);
    chk("st_b", bus.ex_b, 32'h8);
    chk("st_data", bus.ex_store_data, 32'hDEAD);
    chk("st_a", bus.ex_a, 32'h100);
    chk("st_is_store", {31'd0, bus.ex_is_store}, 32'd1);
    chk("st_alu", {27'd0, bus.ex_alusignals}, 32'h0000000f);

    // Unused source never forwards; register 0 forwards like any other.
    step();
    set_ma(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    issue(32'h60, 5'b00110, 4'd4, 1'b0, 32'h22, 4'd0, 1'b1, 32'h1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    clr_of();
    set_ma(1'b1, 1'b1, 1'b0, 4'd4, 32'h66);
    set_rw(1'b1, 1'b1, 4'd0, 32'h77);
    @(negedge clk);
    chk("nouse_a", bus.ex_a, 32'h22);
    chk("r0_b", bus.ex_b, 32'h77);

    step();
    set_ma(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    set_rw(1'b0, 1'b0, 4'd0, 32'd0);
    step();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
